// File: rtl/udp_echo_buf_pkg.sv
// Shared definitions for the UDP echo buffer: FSM encodings and length limit.
package udp_echo_buf_pkg;

  localparam int unsigned MAX_LEN_DEF = 1472;

  typedef enum logic [2:0] {
    R_IDLE,
    R_CHECK,
    R_COPY,
    R_DONE,
    R_WAIT
  } rx_state_t;

  typedef enum logic [1:0] {
    T_IDLE,
    T_REQ,
    T_WAIT
  } tx_state_t;

endpackage

// File: rtl/udp_len_fifo.sv
// Show-ahead queue of packet lengths; head is valid whenever empty is low.
module udp_len_fifo #(
  parameter int unsigned DEPTH_W = 2,
  parameter int unsigned WIDTH   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [WIDTH-1:0]   din,
  input  logic               pop,
  output logic [WIDTH-1:0]   head,
  output logic               full,
  output logic               empty,
  output logic [DEPTH_W:0]   count
);

  localparam int unsigned DEPTH = 1 << DEPTH_W;

  logic [WIDTH-1:0]   mem [DEPTH];
  logic [DEPTH_W-1:0] wr_idx;
  logic [DEPTH_W-1:0] rd_idx;
  logic               do_push;
  logic               do_pop;

  assign full    = (count == (DEPTH_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_idx];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Length storage; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_idx] <= din;
  end

  // Pointer and occupancy tracking; push and pop together leave count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_idx <= '0;
      rd_idx <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_idx <= wr_idx + 1'b1;
      if (do_pop)  rd_idx <= rd_idx + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/udp_echo_buf.sv
// UDP payload echo buffer: copies rx payloads into a circular byte store,
// queues their lengths and replays them on the mac transmit handshake.
module udp_echo_buf
  import udp_echo_buf_pkg::*;
#(
  parameter int unsigned DW          = 8,
  parameter int unsigned ADDR_W      = 11,
  parameter int unsigned PKT_DEPTH_W = 2,
  parameter int unsigned LEN_W       = 16,
  parameter int unsigned MAX_LEN     = MAX_LEN_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   loop_en,
  input  logic                   fs_udp_rx,
  output logic                   fd_udp_rx,
  input  logic [LEN_W-1:0]       udp_rx_len,
  output logic [ADDR_W-1:0]      udp_rx_addr,
  input  logic [DW-1:0]          udp_rxd,
  output logic                   fs_udp_tx,
  input  logic                   fd_udp_tx,
  output logic [LEN_W-1:0]       udp_tx_len,
  input  logic                   flag_udp_tx_req,
  output logic                   udp_txen,
  output logic [DW-1:0]          udp_txd,
  output logic [PKT_DEPTH_W:0]   pkt_cnt,
  output logic [15:0]            drop_cnt
);

  localparam int unsigned BUF_DEPTH = 1 << ADDR_W;

  rx_state_t         rx_state;
  tx_state_t         tx_state;

  logic [LEN_W-1:0]  rx_len;
  logic [LEN_W-1:0]  cp_cnt;
  logic              rx_drop;
  logic [ADDR_W-1:0] wr_ptr;

  logic [LEN_W-1:0]  tx_n;
  logic [ADDR_W-1:0] rd_ptr;

  logic [ADDR_W:0]   used;
  logic [ADDR_W:0]   free_bytes;
  logic [ADDR_W:0]   used_add;
  logic [ADDR_W:0]   used_sub;

  logic [DW-1:0]     mem [BUF_DEPTH];
  logic [DW-1:0]     ram_q;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic              rd_req;
  logic [ADDR_W-1:0] ram_raddr;

  logic              len_push;
  logic              len_pop;
  logic [LEN_W-1:0]  len_head;
  logic              len_full;
  logic              len_empty;
  logic              rx_reject;

  assign free_bytes = (ADDR_W+1)'(BUF_DEPTH) - used;
  assign len_push   = (rx_state == R_DONE) && !rx_drop;
  assign len_pop    = (tx_state == T_REQ) && fd_udp_tx;

  // Data for copy cycle k arrives in cycle k+1, hence the offset of one.
  assign ram_we     = (rx_state == R_COPY) && (cp_cnt != '0);
  assign ram_waddr  = wr_ptr + ADDR_W'(cp_cnt - 1'b1);
  assign rd_req     = (tx_state == T_REQ) && flag_udp_tx_req && (tx_n < udp_tx_len);
  assign ram_raddr  = rd_ptr + ADDR_W'(tx_n);
  assign udp_txd    = udp_txen ? ram_q : '0;

  assign rx_reject  = !loop_en || (udp_rx_len == '0) ||
                      (32'(udp_rx_len) > MAX_LEN) ||
                      (32'(udp_rx_len) > 32'(free_bytes)) || len_full;

  udp_len_fifo #(
    .DEPTH_W (PKT_DEPTH_W),
    .WIDTH   (LEN_W)
  ) u_len_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (len_push),
    .din   (rx_len),
    .pop   (len_pop),
    .head  (len_head),
    .full  (len_full),
    .empty (len_empty),
    .count (pkt_cnt)
  );

  // Byte store: one write port for rx copy, one registered read port for tx.
  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= udp_rxd;
    if (rd_req) ram_q <= mem[ram_raddr];
  end

  // Net occupancy change of commit and release in a single update.
  always_comb begin
    used_add = '0;
    used_sub = '0;
    if (len_push) used_add = (ADDR_W+1)'(rx_len);
    if (len_pop)  used_sub = (ADDR_W+1)'(udp_tx_len);
  end

  // Occupied byte count of the circular store.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) used <= '0;
    else     used <= used + used_add - used_sub;
  end

  // Receive FSM: admit or drop, copy payload from the mac RAM, commit, acknowledge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state    <= R_IDLE;
      rx_len      <= '0;
      cp_cnt      <= '0;
      rx_drop     <= 1'b0;
      wr_ptr      <= '0;
      udp_rx_addr <= '0;
      fd_udp_rx   <= 1'b0;
      drop_cnt    <= '0;
    end else begin
      fd_udp_rx <= 1'b0;
      case (rx_state)
        R_IDLE: begin
          if (fs_udp_rx) rx_state <= R_CHECK;
        end
        R_CHECK: begin
          rx_len      <= udp_rx_len;
          cp_cnt      <= '0;
          udp_rx_addr <= '0;
          if (rx_reject) begin
            rx_drop   <= 1'b1;
            fd_udp_rx <= 1'b1;
            if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
            rx_state  <= R_DONE;
          end else begin
            rx_drop  <= 1'b0;
            rx_state <= R_COPY;
          end
        end
        R_COPY: begin
          cp_cnt <= cp_cnt + 1'b1;
          if ((cp_cnt + 1'b1) < rx_len) udp_rx_addr <= ADDR_W'(cp_cnt + 1'b1);
          if (cp_cnt == rx_len) begin
            fd_udp_rx <= 1'b1;
            rx_state  <= R_DONE;
          end
        end
        R_DONE: begin
          if (!rx_drop) wr_ptr <= wr_ptr + ADDR_W'(rx_len);
          rx_state <= R_WAIT;
        end
        R_WAIT: begin
          if (!fs_udp_rx) rx_state <= R_IDLE;
        end
        default: rx_state <= R_IDLE;
      endcase
    end
  end

  // Transmit FSM: present head packet, serve byte requests, release on frame done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state   <= T_IDLE;
      fs_udp_tx  <= 1'b0;
      udp_tx_len <= '0;
      tx_n       <= '0;
      rd_ptr     <= '0;
      udp_txen   <= 1'b0;
    end else begin
      udp_txen <= rd_req;
      case (tx_state)
        T_IDLE: begin
          if (!len_empty) begin
            fs_udp_tx  <= 1'b1;
            udp_tx_len <= len_head;
            tx_n       <= '0;
            tx_state   <= T_REQ;
          end
        end
        T_REQ: begin
          if (rd_req) tx_n <= tx_n + 1'b1;
          if (fd_udp_tx) begin
            fs_udp_tx <= 1'b0;
            rd_ptr    <= rd_ptr + ADDR_W'(udp_tx_len);
            tx_state  <= T_WAIT;
          end
        end
        T_WAIT: tx_state <= T_IDLE;
        default: tx_state <= T_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_udp_echo_buf.sv
// Directed bench for udp_echo_buf with a small buffer so wrap-around is exercised.
module tb_udp_echo_buf;

  localparam int unsigned AW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          loop_en;
  logic          fs_udp_rx;
  logic          fd_udp_rx;
  logic [15:0]   udp_rx_len;
  logic [AW-1:0] udp_rx_addr;
  logic [7:0]    udp_rxd;
  logic          fs_udp_tx;
  logic          fd_udp_tx;
  logic [15:0]   udp_tx_len;
  logic          flag_udp_tx_req;
  logic          udp_txen;
  logic [7:0]    udp_txd;
  logic [2:0]    pkt_cnt;
  logic [15:0]   drop_cnt;

  logic [7:0]    rx_mem [64];
  int            checks   = 0;
  int            failures = 0;

  typedef struct {
    int   len;
    logic loop;
    logic acc;
    int   drop;
    int   pkt;
    logic fs;
  } vec_t;

  vec_t vec [8];

  udp_echo_buf #(
    .ADDR_W (AW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .loop_en         (loop_en),
    .fs_udp_rx       (fs_udp_rx),
    .fd_udp_rx       (fd_udp_rx),
    .udp_rx_len      (udp_rx_len),
    .udp_rx_addr     (udp_rx_addr),
    .udp_rxd         (udp_rxd),
    .fs_udp_tx       (fs_udp_tx),
    .fd_udp_tx       (fd_udp_tx),
    .udp_tx_len      (udp_tx_len),
    .flag_udp_tx_req (flag_udp_tx_req),
    .udp_txen        (udp_txen),
    .udp_txd         (udp_txd),
    .pkt_cnt         (pkt_cnt),
    .drop_cnt        (drop_cnt)
  );

  always #5 clk = ~clk;

  // mac receive RAM model with one cycle read latency
  always @(posedge clk) udp_rxd <= rx_mem[udp_rx_addr];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [7:0] pbyte(input logic [7:0] seed, input logic [7:0] st, input int i);
    return seed + 8'(i) * st;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_fd_udp_rx"},   32'(fd_udp_rx),   32'd0);
    check({tag, "_udp_rx_addr"}, 32'(udp_rx_addr), 32'd0);
    check({tag, "_fs_udp_tx"},   32'(fs_udp_tx),   32'd0);
    check({tag, "_udp_tx_len"},  32'(udp_tx_len),  32'd0);
    check({tag, "_udp_txen"},    32'(udp_txen),    32'd0);
    check({tag, "_udp_txd"},     32'(udp_txd),     32'd0);
    check({tag, "_pkt_cnt"},     32'(pkt_cnt),     32'd0);
    check({tag, "_drop_cnt"},    32'(drop_cnt),    32'd0);
  endtask

  task automatic load_rx(input int len, input logic [7:0] seed, input logic [7:0] st);
    for (int i = 0; i < len && i < 64; i++) rx_mem[i] = pbyte(seed, st, i);
  endtask

  // Offer one rx packet and check the acknowledge latency in clock edges.
  task automatic rx_pkt(input int len, input logic [7:0] seed, input logic [7:0] st, input int exp_edges);
    int edges;
    load_rx(len, seed, st);
    udp_rx_len = 16'(len);
    fs_udp_rx  = 1'b1;
    edges      = 0;
    while (edges < 200) begin
      step();
      edges++;
      if (fd_udp_rx) break;
    end
    check("rx_fd_latency", 32'(edges), 32'(exp_edges));
    step();
    check("rx_fd_width", 32'(fd_udp_rx), 32'd0);
    fs_udp_rx  = 1'b0;
    udp_rx_len = '0;
    step();
    step();
  endtask

  // Wait for the transmit request and read the head packet byte by byte.
  task automatic tx_read(input int len, input logic [7:0] seed, input logic [7:0] st);
    int n = 0;
    while (!fs_udp_tx && n < 100) begin
      step();
      n++;
    end
    check("tx_fs", 32'(fs_udp_tx), 32'd1);
    check("tx_len", 32'(udp_tx_len), 32'(len));
    check("tx_txen_idle", 32'(udp_txen), 32'd0);
    for (int i = 0; i < len + 2; i++) begin
      flag_udp_tx_req = 1'b1;
      step();
      check("tx_txen", 32'(udp_txen), (i < len) ? 32'd1 : 32'd0);
      check("tx_txd", 32'(udp_txd), (i < len) ? 32'(pbyte(seed, st, i)) : 32'd0);
    end
    flag_udp_tx_req = 1'b0;
  endtask

  task automatic tx_done();
    fd_udp_tx = 1'b1;
    step();
    fd_udp_tx = 1'b0;
    check("tx_fs_release", 32'(fs_udp_tx), 32'd0);
    step();
    step();
  endtask

  task automatic tx_pkt(input int len, input logic [7:0] seed, input logic [7:0] st);
    tx_read(len, seed, st);
    tx_done();
  endtask

  initial begin
    rst             = 1'b1;
    loop_en         = 1'b1;
    fs_udp_rx       = 1'b0;
    udp_rx_len      = '0;
    fd_udp_tx       = 1'b0;
    flag_udp_tx_req = 1'b0;
    for (int i = 0; i < 64; i++) rx_mem[i] = '0;

    vec[0] = '{0,    1'b1, 1'b0, 1, 0, 1'b0};
    vec[1] = '{1473, 1'b1, 1'b0, 2, 0, 1'b0};
    vec[2] = '{8,    1'b0, 1'b0, 3, 0, 1'b0};
    vec[3] = '{16,   1'b1, 1'b1, 3, 1, 1'b1};
    vec[4] = '{16,   1'b1, 1'b1, 3, 2, 1'b1};
    vec[5] = '{16,   1'b1, 1'b1, 3, 3, 1'b1};
    vec[6] = '{16,   1'b1, 1'b1, 3, 4, 1'b1};
    vec[7] = '{16,   1'b1, 1'b0, 4, 4, 1'b1};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    step();
    check_reset_outputs("reset");

    // single echo
    rx_pkt(4, 8'h11, 8'h11, 7);
    tx_pkt(4, 8'h11, 8'h11);
    check("echo_pkt_cnt", 32'(pkt_cnt), 32'd0);

    // illegal lengths, loop disabled, then queue fill with no transmit completion
    for (int k = 0; k < 8; k++) begin
      loop_en = vec[k].loop;
      rx_pkt(vec[k].len, 8'(k * 16), 8'd1, vec[k].acc ? vec[k].len + 3 : 2);
      check("vec_drop_cnt", 32'(drop_cnt), 32'(vec[k].drop));
      check("vec_pkt_cnt", 32'(pkt_cnt), 32'(vec[k].pkt));
      check("vec_fs_udp_tx", 32'(fs_udp_tx), 32'(vec[k].fs));
    end
    loop_en = 1'b1;
    for (int k = 3; k < 7; k++) tx_pkt(16, 8'(k * 16), 8'd1);
    check("drain_pkt_cnt", 32'(pkt_cnt), 32'd0);

    // wrap across the buffer end
    for (int p = 0; p < 3; p++) begin
      rx_pkt(40, 8'(8'hA0 + p * 7), 8'd3, 43);
      tx_pkt(40, 8'(8'hA0 + p * 7), 8'd3);
    end

    // commit of B and release of A in the same cycle
    rx_pkt(8, 8'h55, 8'd2, 11);
    tx_read(8, 8'h55, 8'd2);
    load_rx(10, 8'hC3, 8'd5);
    udp_rx_len = 16'd10;
    fs_udp_rx  = 1'b1;
    repeat (13) step();
    fd_udp_tx = 1'b1;
    check("sim_fd_udp_rx", 32'(fd_udp_rx), 32'd1);
    step();
    fd_udp_tx = 1'b0;
    check("sim_pkt_cnt", 32'(pkt_cnt), 32'd1);
    check("sim_fs_release", 32'(fs_udp_tx), 32'd0);
    fs_udp_rx  = 1'b0;
    udp_rx_len = '0;
    step();
    step();
    tx_pkt(10, 8'hC3, 8'd5);
    check("sim_after_pkt_cnt", 32'(pkt_cnt), 32'd0);
    // a full-buffer packet is only accepted if the byte accounting netted to empty
    rx_pkt(64, 8'h01, 8'd1, 67);
    check("full_drop_cnt", 32'(drop_cnt), 32'd4);
    check("full_pkt_cnt", 32'(pkt_cnt), 32'd1);
    tx_pkt(64, 8'h01, 8'd1);

    // reset in the middle of a copy with another packet still queued
    rx_pkt(4, 8'h21, 8'd1, 7);
    check("pre_rst_pkt_cnt", 32'(pkt_cnt), 32'd1);
    load_rx(10, 8'h30, 8'd1);
    udp_rx_len = 16'd10;
    fs_udp_rx  = 1'b1;
    begin
      int n = 0;
      while (udp_rx_addr != 3 && n < 30) begin
        step();
        n++;
      end
    end
    check("rst_copy_addr", 32'(udp_rx_addr), 32'd3);
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    fs_udp_rx  = 1'b0;
    udp_rx_len = '0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    step();
    rx_pkt(2, 8'h7E, 8'h11, 5);
    tx_pkt(2, 8'h7E, 8'h11);
    check("final_pkt_cnt", 32'(pkt_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
